keypad_scan: RTL and testbench
==============================

# keypad_scan

Input-side counterpart to the multiplexed 7-segment display driver. The display driver scans digits out; this block scans a 4x4 active-low matrix keypad in. It drives one column low at a time, samples the row lines, debounces over whole sweeps and reports one debounced key press as a code plus a one-cycle strobe. It sits between the board's keypad pins and game/control logic such as the reaction-speed core, and runs on the system clock.

## Interface
- `SCAN_DIV`, default 100000: `sysclk` cycles each column stays driven. Must be ≥ 3.
- `DEBOUNCE_SWEEPS`, default 5: number of consecutive agreeing full sweeps needed to accept a press or a release.
- `sysclk`  in  1  system clock. All logic is on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `row_n`  in  4  keypad row lines, active-low, externally pulled up, asynchronous.
- `col_n`  out  4  column drive, active-low, exactly one bit low at any time.
- `key_code`  out  4  code of the last accepted key, = row*4 + col.
- `key_valid`  out  1  one-cycle strobe when a press is accepted.
- `key_held`  out  1  high from acceptance until the debounced release.

## Operation
**Input synchronisation**
- `row_n` passes through a 2-flop synchroniser; the stages reset to 4'b1111.
- Only the synchronised value is used.

**Column scan**
- `div_cnt` counts 0..SCAN_DIV-1.
- When `div_cnt` = SCAN_DIV-1:
  - for the current column c, store `~row_sync[r]` into `map[r*4+c]`;
  - advance `col_n` in the order 1110 → 1101 → 1011 → 0111 → 1110.
- A sweep is complete at the sampling edge of column 3.
- The sweep result is evaluated on the map including the column-3 bits sampled on that edge.

**Candidate selection**
- cand = lowest set index of the 16-bit map, or NONE if the map is zero.
- When several keys are pressed, lowest index wins. Ghost keys are not filtered.

**FSM, evaluated only at sweep completion**
- IDLE:
  - cand = NONE: stay.
  - otherwise: latch k = cand, set cnt = 1, go to DEBOUNCE.
- DEBOUNCE:
  - cand == k: cnt++. When cnt reaches DEBOUNCE_SWEEPS, go to HELD, set `key_code` = k, pulse `key_valid`, set `key_held` = 1.
  - cand == NONE: go to IDLE.
  - cand is a different key: restart with k = cand, cnt = 1.
  - If DEBOUNCE_SWEEPS = 1, acceptance happens straight from IDLE on the first sweep.
- HELD:
  - map bit k clear: cnt_rel++. Otherwise cnt_rel = 0.
  - When cnt_rel reaches DEBOUNCE_SWEEPS, clear `key_held` and go to IDLE.
  - Other keys are ignored while in HELD.
  - If another key is still down after release, it must pass a full debounce from IDLE before it is reported.

**Reset behaviour**
- `col_n` = 4'b1110, `key_code` = 0, `key_valid` = 0, `key_held` = 0.
- map = 0, all counters 0, state IDLE.
- A reset in the middle of DEBOUNCE or HELD discards all progress. No `key_valid` is produced for a key that was mid-debounce.

## Timing
- Sweep length = 4*SCAN_DIV cycles.
- All outputs are registered. `key_valid` and `key_held` change in the cycle after the sweep-completion edge.
- `key_valid` is high for exactly 1 cycle per accepted press, and never during reset.
- Press latency from the first sampled sweep is DEBOUNCE_SWEEPS sweeps. Worst case from a physical press is (DEBOUNCE_SWEEPS+1) sweeps + 3 cycles.
- Release latency matches press latency.
- `key_code` holds its value until the next acceptance.
- Reset has priority over every other event on the same edge.
- Settling: the 2-cycle synchroniser delay is hidden because sampling happens on the last cycle of the column dwell.

## Test plan
Bench settings: SCAN_DIV=4, DEBOUNCE_SWEEPS=3, sweep = 16 cycles. The keypad model pulls `row_n[r]` low when `col_n[c]`=0 and key (r,c) is pressed.

1. **Reset and scan:** hold `reset` for 2 cycles → `col_n`=1110 and all outputs 0. After release, `col_n` steps to 1101, 1011, 0111, 1110 every 4 cycles.
2. **Single clean press:** press (r2,c1) steadily → exactly one `key_valid` pulse with `key_code`=9 within 64+3 cycles of the press, and `key_held`=1. Keep holding for 10 more sweeps → no further pulses.
3. **Bounce rejection:** toggle key 6 pressed/released every sweep (1 sweep on, 1 off) for 12 sweeps → `key_valid` never asserts and `key_held` stays 0.
4. **Priority and handoff:**
   - Press keys 10 and 5 together → `key_code`=5, one pulse.
   - Add key 3 while 5 is held → no pulse.
   - Release 5 with 3 still down → `key_held` falls 3 sweeps later, then one pulse with `key_code`=3 after 3 further sweeps.
5. **Release debounce:** while key 12 is held, release it for 1 sweep and re-press → `key_held` stays 1 and there is no pulse. Release it for 3 sweeps → `key_held` returns to 0.
6. **Reset mid-debounce:** press key 7 and assert `reset` after 2 sweeps → outputs 0 and `col_n`=1110 the next cycle. After release, the key must wait a full 3 sweeps before its single pulse with `key_code`=7.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x4 active-low matrix keypad one column at a time,
// debounces over whole sweeps and reports one accepted key press.
//
// Ports:
//   sysclk     in   1  system clock, rising edge
//   reset      in   1  synchronous active-high reset
//   row_n      in   4  keypad rows, active-low, asynchronous
//   col_n      out  4  column drive, active-low, one-hot low
//   key_code   out  4  code of last accepted key (row*4 + col)
//   key_valid  out  1  one-cycle strobe on press acceptance
//   key_held   out  1  high from acceptance until debounced release
module keypad_scan #(
    parameter int unsigned SCAN_DIV        = 100000,
    parameter int unsigned DEBOUNCE_SWEEPS = 5
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SWEEPS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SWEEPS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_HELD
    } state_t;

    // Scan datapath registers
    logic [3:0]       r_row_s1;
    logic [3:0]       r_row_s2;
    logic [DIV_W-1:0] r_div_cnt;
    logic [1:0]       r_col_idx;
    logic [3:0]       r_col_n;
    logic [15:0]      r_map;

    // FSM registers
    state_t           r_state;
    logic [3:0]       r_key;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cnt_rel;
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             r_key_held;

    // Combinational signals
    logic             w_sample;
    logic             w_sweep_done;
    logic [1:0]       w_col_idx_nxt;
    logic [3:0]       w_col_n_nxt;
    logic [15:0]      w_map_next;
    logic             w_cand_valid;
    logic [3:0]       w_cand;

    state_t           w_state_nxt;
    logic [3:0]       w_key_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_rel_nxt;
    logic [3:0]       w_key_code_nxt;
    logic             w_key_valid_nxt;
    logic             w_key_held_nxt;

    // Sampling on the last dwell cycle hides the synchroniser latency.
    assign w_sample      = (r_div_cnt == DIV_LAST);
    assign w_sweep_done  = w_sample && (r_col_idx == 2'd3);
    assign w_col_idx_nxt = r_col_idx + 2'd1;
    assign w_col_n_nxt   = ~(4'b0001 << w_col_idx_nxt);

    // Map as it will be after this edge's column sample; the sweep is judged on it.
    always_comb begin
        w_map_next = r_map;
        if (w_sample) begin
            for (int r = 0; r < 4; r++) begin
                w_map_next[{2'(r), r_col_idx}] = ~r_row_s2[r];
            end
        end
    end

    // Lowest set index wins; descending loop lets the lowest overwrite last.
    always_comb begin
        w_cand_valid = |w_map_next;
        w_cand       = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_map_next[i]) begin
                w_cand = 4'(i);
            end
        end
    end

    // Synchroniser, column divider and key map
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_row_s1  <= 4'b1111;
            r_row_s2  <= 4'b1111;
            r_div_cnt <= '0;
            r_col_idx <= 2'd0;
            r_col_n   <= 4'b1110;
            r_map     <= 16'd0;
        end else begin
            r_row_s1 <= row_n;
            r_row_s2 <= r_row_s1;
            if (w_sample) begin
                r_div_cnt <= '0;
                r_col_idx <= w_col_idx_nxt;
                r_col_n   <= w_col_n_nxt;
                r_map     <= w_map_next;
            end else begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_key       <= 4'd0;
            r_cnt       <= '0;
            r_cnt_rel   <= '0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_key       <= w_key_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cnt_rel   <= w_cnt_rel_nxt;
            r_key_code  <= w_key_code_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_held  <= w_key_held_nxt;
        end
    end

    // FSM next-state and outputs, advanced once per completed sweep
    always_comb begin
        w_state_nxt     = r_state;
        w_key_nxt       = r_key;
        w_cnt_nxt       = r_cnt;
        w_cnt_rel_nxt   = r_cnt_rel;
        w_key_code_nxt  = r_key_code;
        w_key_valid_nxt = 1'b0;
        w_key_held_nxt  = r_key_held;

        if (w_sweep_done) begin
            case (r_state)
                S_IDLE: begin
                    if (w_cand_valid) begin
                        w_key_nxt = w_cand;
                        w_cnt_nxt = CNT_W'(1);
                        if (CNT_W'(1) == CNT_TARGET) begin
                            w_state_nxt     = S_HELD;
                            w_cnt_rel_nxt   = '0;
                            w_key_code_nxt  = w_cand;
                            w_key_valid_nxt = 1'b1;
                            w_key_held_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (!w_cand_valid) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (w_cand != r_key) begin
                        w_key_nxt = w_cand;
                        w_cnt_nxt = CNT_W'(1);
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if ((r_cnt + CNT_W'(1)) == CNT_TARGET) begin
                            w_state_nxt     = S_HELD;
                            w_cnt_rel_nxt   = '0;
                            w_key_code_nxt  = r_key;
                            w_key_valid_nxt = 1'b1;
                            w_key_held_nxt  = 1'b1;
                        end
                    end
                end
                S_HELD: begin
                    // Only the held key matters; other keys wait for IDLE.
                    if (w_map_next[r_key]) begin
                        w_cnt_rel_nxt = '0;
                    end else if ((r_cnt_rel + CNT_W'(1)) == CNT_TARGET) begin
                        w_state_nxt    = S_IDLE;
                        w_cnt_nxt      = '0;
                        w_cnt_rel_nxt  = '0;
                        w_key_held_nxt = 1'b0;
                    end else begin
                        w_cnt_rel_nxt = r_cnt_rel + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign col_n     = r_col_n;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan with a behavioural 4x4 keypad model.
module tb_keypad_scan;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;
    localparam int          SWEEP    = 16;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = 16'd0;

    int checks    = 0;
    int failures  = 0;
    int pulse_cnt = 0;

    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;
    logic       prev_valid = 1'b0;

    always #5 sysclk = ~sysclk;

    // Keypad: a pressed key shorts its row to its column while that column is low.
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    keypad_scan #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SWEEPS(DEB)
    ) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // Scoreboard: every strobe must match the next expected code and last one cycle.
    always @(negedge sysclk) begin
        if (key_valid) begin
            pulse_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse code=%0d expected=none", key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                if (key_code !== mon_exp) begin
                    failures++;
                    $display("FAIL pulse_code got=%0d exp=%0d", key_code, mon_exp);
                end
            end
            checks++;
            if (prev_valid) begin
                failures++;
                $display("FAIL pulse_width got=2+ cycles exp=1");
            end
        end
        prev_valid = key_valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #1;
        end
    endtask

    task automatic test_reset;
        logic [3:0] exp_col;
        reset   = 1'b1;
        pressed = 16'd0;
        tick(2);
        checks++; if (col_n !== 4'b1110) begin failures++; $display("FAIL reset_col got=%b exp=1110", col_n); end
        checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL reset_code got=%0d exp=0", key_code); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", key_valid); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL reset_held got=%b exp=0", key_held); end
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick(1);
            exp_col = ~(4'b0001 << (((k + 1) / 4) % 4));
            checks++;
            if (col_n !== exp_col) begin
                failures++;
                $display("FAIL scan_col cycle=%0d got=%b exp=%b", k, col_n, exp_col);
            end
        end
    endtask

    task automatic test_single_press;
        int n;
        int base;
        base = pulse_cnt;
        exp_q.push_back(4'd9);
        pressed[9] = 1'b1;
        n = 0;
        while (key_valid !== 1'b1 && n < 67) begin tick(1); n++; end
        checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL press9_timeout got=no_pulse exp=pulse within 67"); end
        checks++; if (key_code !== 4'd9) begin failures++; $display("FAIL press9_code got=%0d exp=9", key_code); end
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL press9_held got=%b exp=1", key_held); end
        tick(10 * SWEEP);
        checks++; if (pulse_cnt !== base + 1) begin failures++; $display("FAIL press9_pulses got=%0d exp=%0d", pulse_cnt - base, 1); end
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL press9_still_held got=%b exp=1", key_held); end
        pressed = 16'd0;
        n = 0;
        while (key_held !== 1'b0 && n < 5 * SWEEP) begin tick(1); n++; end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL press9_release got=%b exp=0", key_held); end
    endtask

    task automatic test_bounce;
        int base;
        int held_hi;
        base    = pulse_cnt;
        held_hi = 0;
        for (int s = 0; s < 12; s++) begin
            pressed[6] = (s % 2 == 0);
            for (int j = 0; j < SWEEP; j++) begin
                tick(1);
                if (key_held === 1'b1) held_hi++;
            end
        end
        pressed = 16'd0;
        tick(2 * SWEEP);
        checks++; if (pulse_cnt !== base) begin failures++; $display("FAIL bounce_pulses got=%0d exp=0", pulse_cnt - base); end
        checks++; if (held_hi !== 0) begin failures++; $display("FAIL bounce_held got=%0d cycles exp=0", held_hi); end
    endtask

    task automatic test_priority_handoff;
        int n;
        int base;
        base = pulse_cnt;
        exp_q.push_back(4'd5);
        pressed[10] = 1'b1;
        pressed[5]  = 1'b1;
        n = 0;
        while (key_valid !== 1'b1 && n < 5 * SWEEP) begin tick(1); n++; end
        checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL prio_timeout got=no_pulse exp=pulse"); end
        checks++; if (key_code !== 4'd5) begin failures++; $display("FAIL prio_code got=%0d exp=5", key_code); end
        pressed[3] = 1'b1;
        tick(4 * SWEEP);
        checks++; if (pulse_cnt !== base + 1) begin failures++; $display("FAIL prio_add3_pulses got=%0d exp=1", pulse_cnt - base); end
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL prio_add3_held got=%b exp=1", key_held); end
        pressed[5] = 1'b0;
        exp_q.push_back(4'd3);
        n = 0;
        while (key_held !== 1'b0 && n < 5 * SWEEP) begin tick(1); n++; end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL handoff_release got=%b exp=0", key_held); end
        checks++; if (key_code !== 4'd5) begin failures++; $display("FAIL handoff_code_hold got=%0d exp=5", key_code); end
        n = 0;
        while (key_valid !== 1'b1 && n < 100) begin tick(1); n++; end
        checks++; if (n !== 3 * SWEEP) begin failures++; $display("FAIL handoff_latency got=%0d exp=%0d", n, 3 * SWEEP); end
        checks++; if (key_code !== 4'd3) begin failures++; $display("FAIL handoff_code got=%0d exp=3", key_code); end
        pressed = 16'd0;
        n = 0;
        while (key_held !== 1'b0 && n < 5 * SWEEP) begin tick(1); n++; end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL handoff_final_release got=%b exp=0", key_held); end
    endtask

    task automatic test_release_debounce;
        int n;
        int base;
        int held_lo;
        base = pulse_cnt;
        exp_q.push_back(4'd12);
        pressed[12] = 1'b1;
        n = 0;
        while (key_valid !== 1'b1 && n < 5 * SWEEP) begin tick(1); n++; end
        checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL rel12_timeout got=no_pulse exp=pulse"); end
        tick(SWEEP);
        held_lo = 0;
        pressed[12] = 1'b0;
        for (int j = 0; j < SWEEP; j++) begin tick(1); if (key_held !== 1'b1) held_lo++; end
        pressed[12] = 1'b1;
        for (int j = 0; j < 4 * SWEEP; j++) begin tick(1); if (key_held !== 1'b1) held_lo++; end
        checks++; if (held_lo !== 0) begin failures++; $display("FAIL rel12_glitch_held got=%0d low cycles exp=0", held_lo); end
        checks++; if (pulse_cnt !== base + 1) begin failures++; $display("FAIL rel12_glitch_pulses got=%0d exp=1", pulse_cnt - base); end
        pressed = 16'd0;
        tick(30);
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL rel12_early_release got=%b exp=1", key_held); end
        n = 0;
        while (key_held !== 1'b0 && n < 50) begin tick(1); n++; end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL rel12_release got=%b exp=0", key_held); end
    endtask

    task automatic test_reset_mid_debounce;
        int first;
        int n;
        pressed[7] = 1'b1;
        tick(2 * SWEEP);
        reset = 1'b1;
        tick(1);
        checks++; if (col_n !== 4'b1110) begin failures++; $display("FAIL midrst_col got=%b exp=1110", col_n); end
        checks++; if (key_code !== 4'd0) begin failures++; $display("FAIL midrst_code got=%0d exp=0", key_code); end
        checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", key_valid); end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL midrst_held got=%b exp=0", key_held); end
        tick(1);
        reset = 1'b0;
        exp_q.push_back(4'd7);
        first = -1;
        for (int k = 0; k < 64; k++) begin
            tick(1);
            if (key_valid === 1'b1 && first < 0) first = k;
        end
        checks++; if (first !== 3 * SWEEP - 1) begin failures++; $display("FAIL midrst_latency got=%0d exp=%0d", first, 3 * SWEEP - 1); end
        checks++; if (key_held !== 1'b1) begin failures++; $display("FAIL midrst_held_after got=%b exp=1", key_held); end
        pressed = 16'd0;
        n = 0;
        while (key_held !== 1'b0 && n < 5 * SWEEP) begin tick(1); n++; end
        checks++; if (key_held !== 1'b0) begin failures++; $display("FAIL midrst_release got=%b exp=0", key_held); end
    endtask

    initial begin
        test_reset;
        test_single_press;
        test_bounce;
        test_priority_handoff;
        test_release_debounce;
        test_reset_mid_debounce;
        tick(2);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_pulses got=%0d outstanding exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
